result_packer: RTL and testbench

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/hpu_pkg.sv | 18 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/result_packer.sv | 107 ++++++++++
 tb/tb_result_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared widths and types for the host packet unit datapath.
package hpu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned ENTRY_W = BEAT_W + 1;

  typedef struct packed {
    logic              last;
    logic [BEAT_W-1:0] data;
  } beat_t;

  typedef enum logic {
    StIdle,
    StPend
  } flush_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr, rd;

  // Writes into a full FIFO and reads from an empty one are dropped.
  assign wr = wr_en & (count_q != (AW+1)'(DEPTH));
  assign rd = rd_en & (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/result_packer.sv
// Pairs 32-bit core results into 64-bit stream beats, tags packet boundaries
// and closes partial packets on flush.
module result_packer
  import hpu_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic [7:0]             pkt_beats,
  input  logic                   flush,
  output logic                   dst_valid,
  output logic [BEAT_W-1:0]      dst_data,
  output logic                   dst_last,
  input  logic                   dst_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  flush_state_e      state_q, state_d;
  logic              flush_pend;
  logic [LW-1:0]     count;
  logic              space;
  logic [DATA_W-1:0] half_q;
  logic              half_valid_q;
  logic [7:0]        push_cnt_q;
  logic              accept, pair_push, flush_need, flush_push, push, pop;
  beat_t             push_beat, head;

  assign space      = (count != LW'(DEPTH));
  assign accept     = in_valid & in_ready;
  assign pair_push  = accept & half_valid_q;
  assign flush_need = half_valid_q | (push_cnt_q != 8'd0);
  // in_ready is low in StPend, so the flush beat never competes with a pair.
  assign flush_push = flush_pend & space & flush_need;
  assign push       = pair_push | flush_push;
  assign pop        = dst_valid & dst_ready;

  always_comb begin
    push_beat.last = (push_cnt_q == pkt_beats - 8'd1) | flush_push;
    if (pair_push) begin
      push_beat.data = {in_data, half_q};
    end else begin
      push_beat.data = {{DATA_W{1'b0}}, (half_valid_q ? half_q : {DATA_W{1'b0}})};
    end
  end

  // Flush FSM: state register, next state, outputs.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (flush) state_d = StPend;
      StPend:  if (space || !flush_need) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    flush_pend = (state_q == StPend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_valid_q <= 1'b0;
      push_cnt_q   <= 8'd0;
    end else begin
      if (accept && !half_valid_q) half_valid_q <= 1'b1;
      else if (push)               half_valid_q <= 1'b0;
      if (push) push_cnt_q <= push_beat.last ? 8'd0 : push_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !half_valid_q) half_q <= in_data;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_beat),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  assign in_ready  = space & ~flush_pend & ~rst;
  assign dst_valid = ~rst & (count != '0);
  assign dst_data  = head.data;
  assign dst_last  = head.last;
  assign level     = rst ? '0 : count;
  assign busy      = ~rst & ((count != '0) | half_valid_q | flush_pend);

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: queue-based reference model checked every
// cycle, plus literal expectations on the emitted beat log.
module tb_result_packer;
  import hpu_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [7:0]  pkt_beats = 8'd2;
  logic        flush = 1'b0;
  logic        dst_valid;
  logic [63:0] dst_data;
  logic        dst_last;
  logic        dst_ready = 1'b0;
  logic [4:0]  level;
  logic        busy;

  result_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pkt_beats (pkt_beats),
    .flush     (flush),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .dst_ready (dst_ready),
    .level     (level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: beats waiting downstream, held low word, beats in open packet.
  logic [64:0] m_q[$];
  logic [31:0] m_half;
  bit          m_half_v = 0;
  int          m_cnt = 0;
  bit          m_pend = 0;
  int          m_accepted = 0;

  always @(posedge clk) begin : model
    int sz;
    int bpp;
    bit do_pop, do_push, was_pend;
    logic [64:0] ent;
    if (rst) begin
      m_q.delete();
      m_half_v = 0;
      m_cnt    = 0;
      m_pend   = 0;
    end else begin
      sz       = m_q.size();
      bpp      = (pkt_beats == 8'd0) ? 256 : int'(pkt_beats);
      do_pop   = (sz != 0) && dst_ready;
      do_push  = 0;
      was_pend = m_pend;
      ent      = '0;
      if (in_valid && sz < DEPTH && !m_pend) begin
        m_accepted++;
        if (m_half_v) begin
          ent      = {(m_cnt + 1 == bpp), in_data, m_half};
          do_push  = 1;
          m_half_v = 0;
        end else begin
          m_half   = in_data;
          m_half_v = 1;
        end
      end
      if (was_pend) begin
        if (m_half_v || m_cnt != 0) begin
          if (sz < DEPTH) begin
            ent      = {1'b1, 32'h0, (m_half_v ? m_half : 32'h0)};
            do_push  = 1;
            m_half_v = 0;
            m_pend   = 0;
          end
        end else begin
          m_pend = 0;
        end
      end else if (flush) begin
        m_pend = 1;
      end
      if (do_push) m_cnt = ent[64] ? 0 : m_cnt + 1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(ent);
    end
  end

  logic [64:0] log_q[$];
  int          dut_acc = 0;

  always @(negedge clk) begin : compare
    bit exp_v;
    exp_v = !rst && (m_q.size() != 0);
    chk("in_ready", 65'(in_ready), 65'(!rst && m_q.size() < DEPTH && !m_pend));
    chk("dst_valid", 65'(dst_valid), 65'(exp_v));
    chk("level", 65'(level), rst ? 65'd0 : 65'(m_q.size()));
    chk("busy", 65'(busy), 65'(!rst && (m_q.size() != 0 || m_half_v || m_pend)));
    if (exp_v) begin
      chk("dst_data", 65'(dst_data), 65'(m_q[0][63:0]));
      chk("dst_last", 65'(dst_last), 65'(m_q[0][64]));
    end
    if (dst_valid && dst_ready) log_q.push_back({dst_last, dst_data});
    if (in_valid && in_ready) dut_acc++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic word(input logic [31:0] d, input bit fl);
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    cyc(1);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  initial begin : stim
    int base, acc0, dacc0, nlast;
    cyc(3);
    chk("rst_level", 65'(level), 65'd0);
    chk("rst_in_ready", 65'(in_ready), 65'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 65'(in_ready), 65'd1);
    cyc(1);

    // Two-beat packets.
    dst_ready = 1'b1;
    base = log_q.size();
    for (int i = 1; i <= 4; i++) word(32'(i), 1'b0);
    cyc(4);
    chk("p2_beat0", log_q[base], {1'b0, 64'h00000002_00000001});
    chk("p2_beat1", log_q[base+1], {1'b1, 64'h00000004_00000003});

    // Three words then flush.
    pkt_beats = 8'd4;
    base = log_q.size();
    for (int i = 1; i <= 3; i++) word(32'(i), 1'b0);
    do_flush();
    cyc(5);
    chk("fl_beat0", log_q[base], {1'b0, 64'h00000002_00000001});
    chk("fl_beat1", log_q[base+1], {1'b1, 64'h00000000_00000003});
    chk("fl_nbeats", 65'(log_q.size() - base), 65'd2);
    chk("fl_busy", 65'(busy), 65'd0);

    // Flush with nothing held.
    base = log_q.size();
    do_flush();
    cyc(4);
    chk("idle_flush_nbeats", 65'(log_q.size() - base), 65'd0);

    // Word and flush together, then zero closing beat.
    base = log_q.size();
    word(32'h5, 1'b0);
    word(32'h6, 1'b1);
    cyc(5);
    chk("zf_beat0", log_q[base], {1'b0, 64'h00000006_00000005});
    chk("zf_beat1", log_q[base+1], {1'b1, 64'h0});

    // Fill to full with downstream stalled.
    pkt_beats = 8'd0;
    dst_ready = 1'b0;
    base  = log_q.size();
    acc0  = m_accepted;
    dacc0 = dut_acc;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("full_model_acc", 65'(m_accepted - acc0), 65'd32);
    chk("full_dut_acc", 65'(dut_acc - dacc0), 65'd32);
    chk("full_level", 65'(level), 65'd16);
    chk("full_in_ready", 65'(in_ready), 65'd0);
    dst_ready = 1'b1;
    cyc(20);
    chk("drain_nbeats", 65'(log_q.size() - base), 65'd16);
    for (int k = 0; k < 16; k++)
      chk("drain_beat", log_q[base+k],
          {1'b0, 32'h100 + 32'(2*k+1), 32'h100 + 32'(2*k)});
    do_flush();
    cyc(4);

    // 256-beat packets.
    base = log_q.size();
    for (int i = 0; i < 512; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(5);
    nlast = 0;
    for (int k = 0; k < 256; k++) if (log_q[base+k][64]) nlast++;
    chk("p256_nbeats", 65'(log_q.size() - base), 65'd256);
    chk("p256_nlast", 65'(nlast), 65'd1);
    chk("p256_last_pos", 65'(log_q[base+255][64]), 65'd1);

    // Reset with data held.
    dst_ready = 1'b0;
    base = log_q.size();
    for (int i = 0; i < 11; i++) word(32'h200 + 32'(i), 1'b0);
    chk("pre_rst_level", 65'(level), 65'd5);
    chk("pre_rst_busy", 65'(busy), 65'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    chk("post_rst_level", 65'(level), 65'd0);
    chk("post_rst_in_ready", 65'(in_ready), 65'd1);
    chk("post_rst_dst_valid", 65'(dst_valid), 65'd0);
    dst_ready = 1'b1;
    cyc(5);
    chk("post_rst_nbeats", 65'(log_q.size() - base), 65'd0);
    chk("post_rst_busy", 65'(busy), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
